// File: rtl/dmem_pkg.sv
// Shared constants and FSM encoding for the data-memory responder.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  localparam int unsigned WCNT_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_e;

endpackage

// File: rtl/dmem_lane_steer.sv
// Byte-lane steering: store byte enables / replicated write data and
// extraction plus sign/zero extension of load data. Purely combinational.
module dmem_lane_steer
  import dmem_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic        signed_i,
  input  logic [1:0]  lane_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rword_i,
  output logic [3:0]  be_o,
  output logic [31:0] wword_o,
  output logic [31:0] rdata_o
);

  logic [1:0]  lane_eff;
  logic [31:0] shifted;

  // Effective lane: halves ignore bit 0, words always start at lane 0
  always_comb begin
    lane_eff = 2'b00;
    case (size_i)
      SZ_BYTE: lane_eff = lane_i;
      SZ_HALF: lane_eff = {lane_i[1], 1'b0};
      default: lane_eff = 2'b00;
    endcase
  end

  assign shifted = rword_i >> {lane_eff, 3'b000};

  // Enables, write-data replication and load extension per access size
  always_comb begin
    be_o    = 4'b0000;
    wword_o = 32'h0;
    rdata_o = 32'h0;
    case (size_i)
      SZ_BYTE: begin
        be_o    = 4'b0001 << lane_eff;
        wword_o = {4{wdata_i[7:0]}};
        rdata_o = {{24{signed_i & shifted[7]}}, shifted[7:0]};
      end
      SZ_HALF: begin
        be_o    = lane_eff[1] ? 4'b1100 : 4'b0011;
        wword_o = {2{wdata_i[15:0]}};
        rdata_o = {{16{signed_i & shifted[15]}}, shifted[15:0]};
      end
      default: begin
        be_o    = 4'b1111;
        wword_o = wdata_i;
        rdata_o = shifted;
      end
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time, programmable wait states,
// byte/half/word stores and sign/zero-extended loads.
// Build option DMEM_ERR_EN: enables alignment/range fault detection (rsp_err);
// without it addresses wrap modulo the array and misaligned bits are masked.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h1001_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned       IDX_W     = $clog2(DEPTH_WORDS);
  localparam bit                HAS_WAIT  = (WAIT_CYCLES != 0);
  localparam logic [WCNT_W-1:0] WAIT_LOAD = WCNT_W'(WAIT_CYCLES - 1);

  state_e              state_q, state_d;
  logic [WCNT_W-1:0]   cnt_q, cnt_d;
  logic                req_ready_q, req_ready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [31:0]         rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;

  logic                we_q, signed_q, fault_q;
  logic [1:0]          size_q;
  logic [31:0]         addr_q, wdata_q;

  logic                cap_c, mem_we_c, fault_c;
  logic [31:0]         off_c, rword_c, wword_c, ldata_c;
  logic [IDX_W-1:0]    idx_c;
  logic [3:0]          be_c;

  logic [31:0]         mem_q [DEPTH_WORDS];

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

`ifdef DMEM_ERR_EN
  localparam logic [32:0] RANGE_BYTES = 33'(DEPTH_WORDS) << 2;
  logic [31:0] req_off_c;
  assign req_off_c = req_addr - BASE_ADDR;
  // Fault decode on the incoming request; addr below base wraps to a huge offset
  always_comb begin
    fault_c = ({1'b0, req_off_c} >= RANGE_BYTES)
           || ((req_size == SZ_HALF) && req_off_c[0])
           || (req_size[1] && (req_off_c[1:0] != 2'b00));
  end
`else
  assign fault_c = 1'b0;
`endif

  // Array addressing from the captured request; index wraps modulo depth
  assign off_c   = addr_q - BASE_ADDR;
  assign idx_c   = IDX_W'(off_c >> 2);
  assign rword_c = mem_q[idx_c];

  dmem_lane_steer u_steer (
    .size_i   (size_q),
    .signed_i (signed_q),
    .lane_i   (off_c[1:0]),
    .wdata_i  (wdata_q),
    .rword_i  (rword_c),
    .be_o     (be_c),
    .wword_o  (wword_c),
    .rdata_o  (ldata_c)
  );

  // State and response registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Request capture on the accept edge
  always_ff @(posedge clk) begin
    if (reset) begin
      we_q     <= 1'b0;
      size_q   <= SZ_BYTE;
      signed_q <= 1'b0;
      addr_q   <= 32'h0;
      wdata_q  <= 32'h0;
      fault_q  <= 1'b0;
    end else if (cap_c) begin
      we_q     <= req_we;
      size_q   <= req_size;
      signed_q <= req_signed;
      addr_q   <= req_addr;
      wdata_q  <= req_wdata;
      fault_q  <= fault_c;
    end
  end

  // Array write with byte-lane enables; reset cancels a pending store
  always_ff @(posedge clk) begin
    if (!reset && mem_we_c) begin
      for (int b = 0; b < 4; b++) begin
        if (be_c[b]) mem_q[idx_c][8*b +: 8] <= wword_c[8*b +: 8];
      end
    end
  end

  // Next-state and registered-output decode
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    cap_c       = 1'b0;
    mem_we_c    = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid && req_ready_q) begin
          cap_c       = 1'b1;
          req_ready_d = 1'b0;
          // A faulting request skips the wait states; ACCESS only reports it
          if (fault_c || !HAS_WAIT) begin
            state_d = ACCESS;
          end else begin
            state_d = WAIT;
            cnt_d   = WAIT_LOAD;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) state_d = ACCESS;
        else             cnt_d   = cnt_q - WCNT_W'(1);
      end
      ACCESS: begin
        state_d     = RESP;
        rsp_valid_d = 1'b1;
        rsp_rdata_d = 32'h0;
        if (fault_q)   rsp_err_d   = 1'b1;
        else if (we_q) mem_we_c    = 1'b1;
        else           rsp_rdata_d = ldata_c;
      end
      RESP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          req_ready_d = 1'b1;
          rsp_valid_d = 1'b0;
          rsp_rdata_d = 32'h0;
          rsp_err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
